block_sad_search: RTL and testbench

- Sits directly downstream of the 6x6 front/back buffer update stage in the stereo pipeline.
- Consumes one left reference block and a stream of right candidate blocks, one candidate per beat.
- Computes the 6x6 sum of absolute differences (SAD) for each candidate in a pipeline.
- Tracks the minimum SAD over a search and emits the best disparity and its SAD when the search ends.

---
 rtl/stereo_pkg.sv | 36 +++
 rtl/block_sad_search_if.sv | 28 ++
 rtl/sad_row.sv | 44 ++++
 rtl/block_sad_search.sv | 136 +++++++++++++
 tb/tb_block_sad_search.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/stereo_pkg.sv
// Shared types and constants for the stereo block-matching SAD search.
package stereo_pkg;

  localparam int BLOCK_SIZE    = 6;
  localparam int PIX_W         = 8;
  localparam int ROW_W         = BLOCK_SIZE * PIX_W;
  localparam int SAD_W         = 14;
  localparam int ROW_SUM_W     = 11;
  localparam int DISP_W        = 6;
  localparam int REJECT_THRESH = 2000;

  typedef logic [ROW_W-1:0]     row_t;
  typedef row_t [BLOCK_SIZE-1:0] block_t;
  typedef logic [SAD_W-1:0]     sad_t;
  typedef logic [ROW_SUM_W-1:0] row_sum_t;
  typedef logic [DISP_W-1:0]    disp_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SEARCH = 1'b1
  } state_e;

  // Side-band tag that travels with each candidate through the pipeline.
  typedef struct packed {
    logic  vld;
    logic  first;
    logic  last;
    disp_t disp;
  } tag_t;

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/block_sad_search_if.sv
// Candidate-beat input bus and search-result output bus of block_sad_search.
interface block_sad_search_if;
  import stereo_pkg::*;

  logic   valid_in;
  logic   first_in;
  logic   last_in;
  disp_t  disp_in;
  block_t left_block;
  block_t right_block;

  logic   busy_out;
  logic   valid_out;
  disp_t  best_disp;
  sad_t   best_sad;
  logic   reject_out;

  modport master (
    output valid_in, first_in, last_in, disp_in, left_block, right_block,
    input  busy_out, valid_out, best_disp, best_sad, reject_out
  );

  modport slave (
    input  valid_in, first_in, last_in, disp_in, left_block, right_block,
    output busy_out, valid_out, best_disp, best_sad, reject_out
  );

endinterface

// File: rtl/sad_row.sv
// One block row: registered per-pixel absolute differences, then registered row sum.
module sad_row
  import stereo_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  row_t     left_row_i,
  input  row_t     right_row_i,
  output row_sum_t row_sum_o
);

  logic [BLOCK_SIZE-1:0][PIX_W-1:0] diff_d, diff_q;
  row_sum_t                         sum_d, sum_q;

  // Unsigned absolute difference per pixel.
  always_comb begin
    diff_d = '0;
    for (int k = 0; k < BLOCK_SIZE; k++) begin
      diff_d[k] = abs_diff(left_row_i[k*PIX_W +: PIX_W], right_row_i[k*PIX_W +: PIX_W]);
    end
  end

  // Row sum of the registered differences (6 * 255 fits in 11 bits).
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < BLOCK_SIZE; k++) begin
      sum_d = sum_d + row_sum_t'(diff_q[k]);
    end
  end

  // S1 and S2 pipeline registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      diff_q <= '0;
      sum_q  <= '0;
    end else begin
      diff_q <= diff_d;
      sum_q  <= sum_d;
    end
  end

  assign row_sum_o = sum_q;

endmodule

// File: rtl/block_sad_search.sv
// 6x6 SAD disparity search: pipelined SAD per candidate, minimum tracking,
// one result pulse per completed search.
// Optional: define SAD_REJECT_EN to flag results whose SAD exceeds REJECT_THRESH.
module block_sad_search
  import stereo_pkg::*;
(
  input  logic clk_in,
  input  logic rst_in,
  block_sad_search_if.slave bus
);

  state_e   state_q, state_d;
  logic     accept;
  tag_t     tag_in, tag_s1_q, tag_s2_q, tag_s3_q;
  row_sum_t row_sum [BLOCK_SIZE];
  sad_t     sad_d, sad_s3_q;
  sad_t     min_q;
  disp_t    best_q;
  logic     trk_last_q;
  logic     valid_out_q;
  sad_t     best_sad_q;
  disp_t    best_disp_q;

  // Search FSM: decides which beats enter the pipeline.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.valid_in && bus.first_in) begin
          accept  = 1'b1;
          state_d = bus.last_in ? ST_IDLE : ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (bus.valid_in) begin
          accept = 1'b1;
          if (bus.last_in) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign tag_in = '{vld: accept, first: bus.first_in, last: bus.last_in, disp: bus.disp_in};

  for (genvar r = 0; r < BLOCK_SIZE; r++) begin : g_row
    sad_row u_row (
      .clk_i       (clk_in),
      .rst_i       (rst_in),
      .left_row_i  (bus.left_block[r]),
      .right_row_i (bus.right_block[r]),
      .row_sum_o   (row_sum[r])
    );
  end

  // Block SAD from the six row sums.
  always_comb begin
    sad_d = '0;
    for (int r = 0; r < BLOCK_SIZE; r++) begin
      sad_d = sad_d + sad_t'(row_sum[r]);
    end
  end

  // Tag pipeline alongside S1/S2 and the S3 block SAD register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tag_s1_q <= '0;
      tag_s2_q <= '0;
      tag_s3_q <= '0;
      sad_s3_q <= '0;
    end else begin
      tag_s1_q <= tag_in;
      tag_s2_q <= tag_s1_q;
      tag_s3_q <= tag_s2_q;
      sad_s3_q <= sad_d;
    end
  end

  // Minimum tracker: first tag reloads, otherwise strict less-than keeps the earlier candidate on ties.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      min_q      <= '1;
      best_q     <= '0;
      trk_last_q <= 1'b0;
    end else begin
      trk_last_q <= tag_s3_q.vld && tag_s3_q.last;
      if (tag_s3_q.vld && (tag_s3_q.first || (sad_s3_q < min_q))) begin
        min_q  <= sad_s3_q;
        best_q <= tag_s3_q.disp;
      end
    end
  end

  // Result register: captures the tracker one cycle after the last candidate, holds between pulses.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_out_q <= 1'b0;
      best_sad_q  <= '0;
      best_disp_q <= '0;
    end else begin
      valid_out_q <= trk_last_q;
      if (trk_last_q) begin
        best_sad_q  <= min_q;
        best_disp_q <= best_q;
      end
    end
  end

`ifdef SAD_REJECT_EN
  logic reject_q;

  // Reliability flag, updated together with each result pulse.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)          reject_q <= 1'b0;
    else if (trk_last_q) reject_q <= (min_q > sad_t'(REJECT_THRESH));
  end

  assign bus.reject_out = reject_q;
`else
  assign bus.reject_out = 1'b0;
`endif

  assign bus.valid_out = valid_out_q;
  assign bus.best_sad  = best_sad_q;
  assign bus.best_disp = best_disp_q;
  assign bus.busy_out  = (state_q == ST_SEARCH) || tag_s1_q.vld || tag_s2_q.vld ||
                         tag_s3_q.vld || trk_last_q;

endmodule

// File: tb/tb_block_sad_search.sv
// Directed self-checking bench for block_sad_search.
module tb_block_sad_search;
  import stereo_pkg::*;

`ifdef SAD_REJECT_EN
  localparam logic REJ_ON = 1'b1;
`else
  localparam logic REJ_ON = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   n_asserts = 0;
  int   n_fail = 0;

  block_sad_search_if bus ();

  block_sad_search dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic block_t fill(input logic [7:0] v);
    block_t b;
    b = '0;
    for (int r = 0; r < BLOCK_SIZE; r++)
      for (int k = 0; k < BLOCK_SIZE; k++)
        b[r][k*8 +: 8] = v;
    return b;
  endfunction

  // Right block whose SAD against an all-zero left block equals s.
  function automatic block_t sad_blk(input int s);
    block_t b;
    int     rem;
    int     v;
    b   = '0;
    rem = s;
    for (int r = 0; r < BLOCK_SIZE; r++)
      for (int k = 0; k < BLOCK_SIZE; k++) begin
        v = (rem > 255) ? 255 : rem;
        b[r][k*8 +: 8] = v[7:0];
        rem -= v;
      end
    return b;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic beat(input logic f, input logic l, input int d, input block_t lb, input block_t rb);
    bus.valid_in    = 1'b1;
    bus.first_in    = f;
    bus.last_in     = l;
    bus.disp_in     = disp_t'(d);
    bus.left_block  = lb;
    bus.right_block = rb;
    tick();
    bus.valid_in = 1'b0;
    bus.first_in = 1'b0;
    bus.last_in  = 1'b0;
  endtask

  task automatic zbeat(input logic f, input logic l, input int d, input int s);
    beat(f, l, d, fill(8'h00), sad_blk(s));
  endtask

  task automatic check_pulse(input string tag, input int d, input int s);
    check({tag, "_valid"}, 32'(bus.valid_out), 32'd1);
    check({tag, "_sad"},   32'(bus.best_sad),  32'(s));
    check({tag, "_disp"},  32'(bus.best_disp), 32'(d));
  endtask

  // Called just after the last beat returned (edge N + 1ns): expect quiet to N+3, pulse at N+4.
  task automatic expect_result(input string tag, input int d, input int s);
    tick(); tick(); tick();
    check({tag, "_early"}, 32'(bus.valid_out), 32'd0);
    tick();
    check_pulse(tag, d, s);
    tick();
    check({tag, "_one_cycle"}, 32'(bus.valid_out), 32'd0);
    check({tag, "_hold"},      32'(bus.best_sad),  32'(s));
  endtask

  initial begin
    bus.valid_in    = 1'b0;
    bus.first_in    = 1'b0;
    bus.last_in     = 1'b0;
    bus.disp_in     = '0;
    bus.left_block  = '0;
    bus.right_block = '0;
    tick(); tick();
    check("rst_valid",  32'(bus.valid_out),  32'd0);
    check("rst_sad",    32'(bus.best_sad),   32'd0);
    check("rst_disp",   32'(bus.best_disp),  32'd0);
    check("rst_busy",   32'(bus.busy_out),   32'd0);
    check("rst_reject", 32'(bus.reject_out), 32'd0);
    rst_in = 1'b0;
    tick();

    // Single candidate: |0x10-0x0A| * 36 = 216.
    beat(1'b1, 1'b1, 3, fill(8'h10), fill(8'h0A));
    check("single_busy", 32'(bus.busy_out), 32'd1);
    expect_result("single", 3, 216);
    check("single_idle", 32'(bus.busy_out), 32'd0);

    // Right pixels larger than left: same magnitude.
    beat(1'b1, 1'b1, 7, fill(8'h0A), fill(8'h10));
    expect_result("abs_swap", 7, 216);

    // Five-beat search, minimum at the end.
    zbeat(1'b1, 1'b0, 0, 500);
    check("search_busy", 32'(bus.busy_out), 32'd1);
    zbeat(1'b0, 1'b0, 1, 300);
    zbeat(1'b0, 1'b0, 2, 300);
    zbeat(1'b0, 1'b0, 3, 900);
    zbeat(1'b0, 1'b1, 4, 120);
    expect_result("five", 4, 120);

    // Tie keeps the earlier candidate.
    zbeat(1'b1, 1'b0, 0, 500);
    zbeat(1'b0, 1'b0, 1, 300);
    zbeat(1'b0, 1'b1, 2, 300);
    expect_result("tie", 1, 300);

    // Extremes.
    beat(1'b1, 1'b1, 5, fill(8'hFF), fill(8'h00));
    expect_result("max", 5, 9180);
    check("max_reject", 32'(bus.reject_out), 32'(REJ_ON));
    beat(1'b1, 1'b1, 6, fill(8'h5A), fill(8'h5A));
    expect_result("zero", 6, 0);
    check("zero_reject", 32'(bus.reject_out), 32'd0);

    // Reject threshold boundary.
    zbeat(1'b1, 1'b1, 9, 2001);
    expect_result("thr2001", 9, 2001);
    check("thr2001_reject", 32'(bus.reject_out), 32'(REJ_ON));
    zbeat(1'b1, 1'b1, 10, 2000);
    expect_result("thr2000", 10, 2000);
    check("thr2000_reject", 32'(bus.reject_out), 32'd0);

    // Back-to-back: last beats at edges N and N+2, pulses at N+4 and N+6.
    zbeat(1'b1, 1'b0, 5, 400);
    zbeat(1'b0, 1'b0, 6, 100);
    zbeat(1'b0, 1'b1, 7, 250);
    zbeat(1'b1, 1'b0, 10, 50);
    zbeat(1'b0, 1'b1, 11, 60);
    tick();
    check("b2b_gap", 32'(bus.valid_out), 32'd0);
    tick();
    check_pulse("b2b_a", 6, 100);
    tick();
    check("b2b_between", 32'(bus.valid_out), 32'd0);
    check("b2b_hold_a",  32'(bus.best_disp), 32'd6);
    tick();
    check_pulse("b2b_b", 10, 50);
    tick();
    check("b2b_end", 32'(bus.valid_out), 32'd0);

    // Restart mid-search: only the restarted search reports.
    zbeat(1'b1, 1'b0, 0, 10);
    zbeat(1'b0, 1'b0, 1, 20);
    zbeat(1'b1, 1'b0, 2, 700);
    zbeat(1'b0, 1'b1, 3, 800);
    expect_result("restart", 2, 700);

    // Beat without first while idle is dropped.
    zbeat(1'b0, 1'b1, 12, 0);
    check("drop_busy", 32'(bus.busy_out), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("drop_quiet", 32'(bus.valid_out), 32'd0);
    end
    check("drop_keep", 32'(bus.best_sad), 32'd700);

    // Asynchronous reset two cycles after a last beat.
    zbeat(1'b1, 1'b0, 20, 33);
    zbeat(1'b0, 1'b1, 21, 44);
    tick(); tick();
    #2 rst_in = 1'b1;
    #1;
    check("arst_valid",  32'(bus.valid_out),  32'd0);
    check("arst_sad",    32'(bus.best_sad),   32'd0);
    check("arst_disp",   32'(bus.best_disp),  32'd0);
    check("arst_busy",   32'(bus.busy_out),   32'd0);
    check("arst_reject", 32'(bus.reject_out), 32'd0);
    tick(); tick();
    rst_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("arst_quiet", 32'(bus.valid_out), 32'd0);
    end
    check("arst_sad_hold", 32'(bus.best_sad), 32'd0);

    // Recovery after reset.
    zbeat(1'b1, 1'b1, 8, 77);
    expect_result("post_rst", 8, 77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
